// File: rtl/mcycle_defs_pkg.sv
// rtl/mcycle_defs_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
//
// Purpose: state encodings, opcode/funct constants, ALU_operation codes,
//          ALU class codes and the per-state control strobe decode.
// Ports:   none (package).
package mcycle_defs;

  // State encodings
  localparam logic [4:0] ST_IF     = 5'd0;
  localparam logic [4:0] ST_ID     = 5'd1;
  localparam logic [4:0] ST_EX_R   = 5'd2;
  localparam logic [4:0] ST_WB_R   = 5'd3;
  localparam logic [4:0] ST_EX_MEM = 5'd4;
  localparam logic [4:0] ST_MEM_RD = 5'd5;
  localparam logic [4:0] ST_WB_LW  = 5'd6;
  localparam logic [4:0] ST_MEM_WR = 5'd7;
  localparam logic [4:0] ST_EX_BEQ = 5'd8;
  localparam logic [4:0] ST_EX_BNE = 5'd9;
  localparam logic [4:0] ST_EX_J   = 5'd10;
  localparam logic [4:0] ST_EX_JAL = 5'd11;
  localparam logic [4:0] ST_EX_JR  = 5'd12;
  localparam logic [4:0] ST_EX_I   = 5'd13;
  localparam logic [4:0] ST_WB_I   = 5'd14;
  localparam logic [4:0] ST_WB_LUI = 5'd15;

  typedef enum logic [4:0] {
    S_IF     = ST_IF,
    S_ID     = ST_ID,
    S_EX_R   = ST_EX_R,
    S_WB_R   = ST_WB_R,
    S_EX_MEM = ST_EX_MEM,
    S_MEM_RD = ST_MEM_RD,
    S_WB_LW  = ST_WB_LW,
    S_MEM_WR = ST_MEM_WR,
    S_EX_BEQ = ST_EX_BEQ,
    S_EX_BNE = ST_EX_BNE,
    S_EX_J   = ST_EX_J,
    S_EX_JAL = ST_EX_JAL,
    S_EX_JR  = ST_EX_JR,
    S_EX_I   = ST_EX_I,
    S_WB_I   = ST_WB_I,
    S_WB_LUI = ST_WB_LUI
  } state_t;

  // Opcodes (Inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Funct codes (Inst[5:0])
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU_operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU classes handed to alu_dec
  localparam logic [1:0] AC_ADD   = 2'b00;
  localparam logic [1:0] AC_SUB   = 2'b01;
  localparam logic [1:0] AC_FUNCT = 2'b10;
  localparam logic [1:0] AC_IMM   = 2'b11;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       beq;
    logic       alu_en;     // state drives the ALU; otherwise ALU_operation reads 000
    logic [1:0] alu_class;
    logic       exc;
  } ctrl_t;

  // Moore decode of the strobes for one state. ovf only matters in the
  // write-back states, where a trapped overflow suppresses the write.
  function automatic ctrl_t ctrl_decode(input state_t s, input logic ovf);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF: begin
        c.mem_read  = 1'b1;
        c.iord      = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_en    = 1'b1;
        c.alu_class = AC_ADD;
        c.pc_write  = 1'b1;
      end
      S_ID: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b11;
        c.alu_en    = 1'b1;
        c.alu_class = AC_ADD;
      end
      S_EX_R: begin
        c.alu_en    = 1'b1;
        c.alu_class = AC_FUNCT;
      end
      S_WB_R: begin
        c.reg_dst   = 2'b01;
        c.reg_write = ~ovf;
        c.exc       = ovf;
      end
      S_EX_MEM: begin
        c.alu_src_b = 2'b10;
        c.alu_en    = 1'b1;
        c.alu_class = AC_ADD;
      end
      S_MEM_RD: c.mem_read = 1'b1;
      S_WB_LW: begin
        c.mem_to_reg = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEM_WR: c.mem_write = 1'b1;
      S_EX_BEQ, S_EX_BNE: begin
        c.alu_en        = 1'b1;
        c.alu_class     = AC_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.beq           = (s == S_EX_BEQ);
      end
      S_EX_J: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_EX_JAL: begin
        c.reg_dst    = 2'b10;
        c.mem_to_reg = 2'b11;
        c.reg_write  = 1'b1;
        c.pc_write   = 1'b1;
        c.pc_source  = 2'b10;
      end
      S_EX_JR: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b11;
      end
      S_EX_I: begin
        c.alu_src_b = 2'b10;
        c.alu_en    = 1'b1;
        c.alu_class = AC_IMM;
      end
      S_WB_I: begin
        c.reg_write = ~ovf;
        c.exc       = ovf;
      end
      S_WB_LUI: begin
        c.mem_to_reg = 2'b10;
        c.reg_write  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mcycle_ctrl_alu_dec.sv
// rtl/mcycle_ctrl_alu_dec.sv - ALU class to ALU_operation decoder
//
// Purpose: combinational map of (ALU class, funct, opcode) to the 3-bit
//          ALU_operation code.
// Ports:   alu_class in 2 (add/sub/funct/imm-op), funct in 6, opcode in 6,
//          alu_op out 3.
module alu_dec
  import mcycle_defs::*;
(
  input  logic [1:0] alu_class,
  input  logic [5:0] funct,
  input  logic [5:0] opcode,
  output logic [2:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (alu_class)
      AC_ADD: alu_op = ALU_ADD;
      AC_SUB: alu_op = ALU_SUB;
      AC_FUNCT: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SRL:  alu_op = ALU_SRL;
          default: alu_op = ALU_ADD;
        endcase
      end
      AC_IMM: begin
        case (opcode)
          OP_ADDI: alu_op = ALU_ADD;
          OP_SLTI: alu_op = ALU_SLT;
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// rtl/mcycle_ctrl.sv - multi-cycle MIPS control FSM
//
// Purpose: sequences the data path strobes of a multi-cycle MIPS CPU and
//          handshakes memory transfers on MIO_ready. All outputs are
//          registered Moore outputs: they are decoded from the next state and
//          captured on the same edge as the state, so they always match state.
// Optional: MCTRL_OVF_TRAP_EN - trap add/sub/addi overflow: suppress the
//          write-back and pulse exc for one cycle.
// Ports:   clk, reset (sync, active-high), Inst_in[31:0], MIO_ready, zero,
//          overflow; MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegDst[1:0],
//          RegWrite, MemtoReg[1:0], ALUSrcA, ALUSrcB[1:0], PCSource[1:0],
//          PCWrite, PCWriteCond, Beq, ALU_operation[2:0], state[4:0], exc.
module mcycle_ctrl
  import mcycle_defs::*;
#(
  parameter logic [4:0] RESET_STATE = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst_in,
  input  logic        MIO_ready,
  input  logic        zero,
  input  logic        overflow,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        CPU_MIO,
  output logic        IorD,
  output logic        IRWrite,
  output logic [1:0]  RegDst,
  output logic        RegWrite,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Beq,
  output logic [2:0]  ALU_operation,
  output logic [4:0]  state,
  output logic        exc
);

  state_t     state_q, state_d, next_state;
  ctrl_t      ctrl_q, ctrl_d;
  logic [2:0] alu_op_q, alu_op_d, alu_op_raw;
  logic       ovf_d;
  logic [5:0] opcode, funct;

`ifdef MCTRL_OVF_TRAP_EN
  logic       ovf_q;
`endif

  assign opcode = Inst_in[31:26];
  assign funct  = Inst_in[5:0];

  always_comb begin
    next_state = state_q;
    case (state_q)
      S_IF:     next_state = MIO_ready ? S_ID : S_IF;
      S_ID: begin
        case (opcode)
          OP_RTYPE:                           next_state = (funct == FN_JR) ? S_EX_JR : S_EX_R;
          OP_LW, OP_SW:                       next_state = S_EX_MEM;
          OP_BEQ:                             next_state = S_EX_BEQ;
          OP_BNE:                             next_state = S_EX_BNE;
          OP_J:                               next_state = S_EX_J;
          OP_JAL:                             next_state = S_EX_JAL;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  next_state = S_EX_I;
          OP_LUI:                             next_state = S_WB_LUI;
          default:                            next_state = S_IF;
        endcase
      end
      S_EX_R:   next_state = S_WB_R;
      S_EX_MEM: next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: next_state = MIO_ready ? S_WB_LW : S_MEM_RD;
      S_MEM_WR: next_state = MIO_ready ? S_IF : S_MEM_WR;
      S_EX_I:   next_state = S_WB_I;
      default:  next_state = S_IF;
    endcase

    // Overflow is only sampled on the EX cycle of a trapping op and lives
    // for exactly the following write-back cycle.
    ovf_d = 1'b0;
`ifdef MCTRL_OVF_TRAP_EN
    if (state_q == S_EX_R && (funct == FN_ADD || funct == FN_SUB))
      ovf_d = overflow;
    if (state_q == S_EX_I && opcode == OP_ADDI)
      ovf_d = overflow;
`endif

    // Decoding the reset target here lets the IF strobes appear on the
    // very cycle after reset, and drops any pending memory request at once.
    if (reset) begin
      state_d = state_t'(RESET_STATE);
      ovf_d   = 1'b0;
    end else begin
      state_d = next_state;
    end

    ctrl_d   = ctrl_decode(state_d, ovf_d);
    alu_op_d = ctrl_d.alu_en ? alu_op_raw : 3'b000;
  end

  alu_dec u_alu_dec (
    .alu_class (ctrl_d.alu_class),
    .funct     (funct),
    .opcode    (opcode),
    .alu_op    (alu_op_raw)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= state_t'(RESET_STATE);
      ctrl_q   <= ctrl_d;
      alu_op_q <= alu_op_d;
`ifdef MCTRL_OVF_TRAP_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      alu_op_q <= alu_op_d;
`ifdef MCTRL_OVF_TRAP_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign MemRead       = ctrl_q.mem_read;
  assign MemWrite      = ctrl_q.mem_write;
  assign CPU_MIO       = ctrl_q.mem_read | ctrl_q.mem_write;
  assign IorD          = ctrl_q.iord;
  assign IRWrite       = ctrl_q.ir_write;
  assign RegDst        = ctrl_q.reg_dst;
  assign RegWrite      = ctrl_q.reg_write;
  assign MemtoReg      = ctrl_q.mem_to_reg;
  assign ALUSrcA       = ctrl_q.alu_src_a;
  assign ALUSrcB       = ctrl_q.alu_src_b;
  assign PCSource      = ctrl_q.pc_source;
  assign PCWrite       = ctrl_q.pc_write;
  assign PCWriteCond   = ctrl_q.pc_write_cond;
  assign Beq           = ctrl_q.beq;
  assign ALU_operation = alu_op_q;
  assign state         = state_q;
`ifdef MCTRL_OVF_TRAP_EN
  assign exc           = ctrl_q.exc & ovf_q;
`else
  assign exc           = 1'b0;
`endif

  // zero is consumed by the data path via PCWriteCond/Beq; the middle
  // instruction fields are decoded there as well.
  logic unused_inputs;
`ifdef MCTRL_OVF_TRAP_EN
  assign unused_inputs = ^{zero, Inst_in[25:6], ctrl_q.alu_en, ctrl_q.alu_class};
`else
  assign unused_inputs = ^{zero, overflow, Inst_in[25:6], ctrl_q.alu_en,
                           ctrl_q.alu_class, ctrl_q.exc, ovf_d};
`endif

endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb/tb_mcycle_ctrl.sv - directed self-checking bench for mcycle_ctrl
module tb_mcycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Inst_in;
  logic        MIO_ready;
  logic        zero;
  logic        overflow;
  logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic        ALUSrcA, PCWrite, PCWriteCond, Beq, exc;
  logic [2:0]  ALU_operation;
  logic [4:0]  state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mcycle_ctrl dut (
    .clk(clk), .reset(reset), .Inst_in(Inst_in), .MIO_ready(MIO_ready),
    .zero(zero), .overflow(overflow),
    .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO), .IorD(IorD),
    .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .Beq(Beq), .ALU_operation(ALU_operation),
    .state(state), .exc(exc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; Inst_in = 32'h0; MIO_ready = 1'b1; zero = 1'b0; overflow = 1'b0;
    step(); step();
    chk("rst_state", 32'(state), 0);
    chk("rst_memread", 32'(MemRead), 1);
    chk("rst_iord", 32'(IorD), 1);
    chk("rst_irwrite", 32'(IRWrite), 1);
    chk("rst_alusrcb", 32'(ALUSrcB), 1);
    chk("rst_regwrite", 32'(RegWrite), 0);
    chk("rst_exc", 32'(exc), 0);

    // IF waits for memory
    reset = 1'b0; MIO_ready = 1'b0;
    step(); chk("if_hold", 32'(state), 0);

    // add $3,$1,$2
    Inst_in = 32'h00221820; MIO_ready = 1'b1;
    step(); chk("add_id_state", 32'(state), 1);
    chk("add_id_alusrcb", 32'(ALUSrcB), 3);
    chk("add_id_alusrca", 32'(ALUSrcA), 1);
    chk("add_id_memread", 32'(MemRead), 0);
    step(); chk("add_ex_state", 32'(state), 2);
    chk("add_ex_aluop", 32'(ALU_operation), 2);
    chk("add_ex_alusrca", 32'(ALUSrcA), 0);
    chk("add_ex_regwrite", 32'(RegWrite), 0);
    step(); chk("add_wb_state", 32'(state), 3);
    chk("add_wb_regwrite", 32'(RegWrite), 1);
    chk("add_wb_regdst", 32'(RegDst), 1);
    chk("add_wb_memtoreg", 32'(MemtoReg), 0);
    step(); chk("add_if_state", 32'(state), 0);
    chk("add_if_regwrite", 32'(RegWrite), 0);

    // sub $3,$1,$2
    Inst_in = 32'h00221822;
    step(); step(); chk("sub_ex_aluop", 32'(ALU_operation), 6);
    step(); step(); chk("sub_if_state", 32'(state), 0);

    // lw $2,4($1) with 3 wait cycles
    Inst_in = 32'h8C220004;
    step(); step(); chk("lw_exmem_state", 32'(state), 4);
    chk("lw_exmem_alusrcb", 32'(ALUSrcB), 2);
    chk("lw_exmem_aluop", 32'(ALU_operation), 2);
    MIO_ready = 1'b0;
    step(); chk("lw_memrd_state", 32'(state), 5);
    chk("lw_memrd_memread", 32'(MemRead), 1);
    chk("lw_memrd_iord", 32'(IorD), 0);
    chk("lw_memrd_cpumio", 32'(CPU_MIO), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lw_wait_state", 32'(state), 5);
      chk("lw_wait_memread", 32'(MemRead), 1);
    end
    MIO_ready = 1'b1;
    step(); chk("lw_wb_state", 32'(state), 6);
    chk("lw_wb_memtoreg", 32'(MemtoReg), 1);
    chk("lw_wb_regwrite", 32'(RegWrite), 1);
    chk("lw_wb_regdst", 32'(RegDst), 0);
    chk("lw_wb_memread", 32'(MemRead), 0);
    step(); chk("lw_if_state", 32'(state), 0);

    // reset held 2 cycles during MEM_RD
    step(); step(); MIO_ready = 1'b0;
    step(); chk("rstmem_memrd_state", 32'(state), 5);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rstmem_state", 32'(state), 0);
      chk("rstmem_memread", 32'(MemRead), 1);
      chk("rstmem_iord", 32'(IorD), 1);
      chk("rstmem_regwrite", 32'(RegWrite), 0);
    end
    reset = 1'b0; MIO_ready = 1'b1;

    // sw $2,4($1)
    Inst_in = 32'hAC220004;
    step(); step(); chk("sw_exmem_state", 32'(state), 4);
    step(); chk("sw_memwr_state", 32'(state), 7);
    chk("sw_memwr_memwrite", 32'(MemWrite), 1);
    chk("sw_memwr_memread", 32'(MemRead), 0);
    chk("sw_memwr_iord", 32'(IorD), 0);
    chk("sw_memwr_cpumio", 32'(CPU_MIO), 1);
    step(); chk("sw_if_state", 32'(state), 0);

    // bne
    Inst_in = 32'h14220003;
    step(); step(); chk("bne_state", 32'(state), 9);
    chk("bne_pcwritecond", 32'(PCWriteCond), 1);
    chk("bne_beq", 32'(Beq), 0);
    chk("bne_pcsource", 32'(PCSource), 1);
    chk("bne_aluop", 32'(ALU_operation), 6);
    chk("bne_pcwrite", 32'(PCWrite), 0);
    step(); chk("bne_if_state", 32'(state), 0);

    // beq
    Inst_in = 32'h10220003;
    step(); step(); chk("beq_state", 32'(state), 8);
    chk("beq_beq", 32'(Beq), 1);
    step();

    // jal
    Inst_in = 32'h0C000010;
    step(); step(); chk("jal_state", 32'(state), 11);
    chk("jal_regwrite", 32'(RegWrite), 1);
    chk("jal_regdst", 32'(RegDst), 2);
    chk("jal_memtoreg", 32'(MemtoReg), 3);
    chk("jal_pcwrite", 32'(PCWrite), 1);
    chk("jal_pcsource", 32'(PCSource), 2);
    step(); chk("jal_if_state", 32'(state), 0);

    // jr $31
    Inst_in = 32'h03E00008;
    step(); step(); chk("jr_state", 32'(state), 12);
    chk("jr_pcwrite", 32'(PCWrite), 1);
    chk("jr_pcsource", 32'(PCSource), 3);
    step();

    // lui
    Inst_in = 32'h3C011234;
    step(); step(); chk("lui_state", 32'(state), 15);
    chk("lui_memtoreg", 32'(MemtoReg), 2);
    chk("lui_regwrite", 32'(RegWrite), 1);
    step();

    // ori
    Inst_in = 32'h34220005;
    step(); step(); chk("ori_ex_state", 32'(state), 13);
    chk("ori_ex_aluop", 32'(ALU_operation), 1);
    chk("ori_ex_alusrcb", 32'(ALUSrcB), 2);
    step(); chk("ori_wb_state", 32'(state), 14);
    chk("ori_wb_regwrite", 32'(RegWrite), 1);
    chk("ori_wb_regdst", 32'(RegDst), 0);
    step();

    // unknown opcode falls back to IF from ID
    Inst_in = 32'hFC000000;
    step(); chk("nop_id_state", 32'(state), 1);
    step(); chk("nop_if_state", 32'(state), 0);

    // add with overflow in EX_R
    Inst_in = 32'h00221820;
    step(); step(); chk("ovf_ex_state", 32'(state), 2);
    overflow = 1'b1;
    step(); overflow = 1'b0;
    chk("ovf_wb_state", 32'(state), 3);
`ifdef MCTRL_OVF_TRAP_EN
    chk("ovf_wb_regwrite", 32'(RegWrite), 0);
    chk("ovf_wb_exc", 32'(exc), 1);
`else
    chk("ovf_wb_regwrite", 32'(RegWrite), 1);
    chk("ovf_wb_exc", 32'(exc), 0);
`endif
    step(); chk("ovf_if_exc", 32'(exc), 0);
    chk("ovf_if_state", 32'(state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mcycle_ctrl.md
Name: mcycle_ctrl

Overview:
- Multi-cycle MIPS control FSM sitting directly upstream of the CPU data path.
- Decodes the latched instruction and sequences the data path control strobes: IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA/B, PCSource, PCWrite, PCWriteCond, Beq, ALU_operation.
- Also drives the memory read/write requests and waits on the MIO_ready handshake.

Parameters:
- RESET_STATE, 5'd0, state entered on reset (IF).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Inst_in  in  32  instruction register contents from the data path
- MIO_ready  in  1  memory/IO transfer complete this cycle
- zero  in  1  ALU zero flag
- overflow  in  1  ALU overflow flag
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- CPU_MIO  out  1  memory access in progress (MemRead|MemWrite)
- IorD  out  1  1 = address from PC, 0 = address from ALU_Out
- IRWrite  out  1  load instruction register
- RegDst  out  2  00 rt, 01 rd, 10 $31
- RegWrite  out  1  register file write enable
- MemtoReg  out  2  00 ALU_Out, 01 MDR, 10 {imm,16'h0}, 11 PC
- ALUSrcA  out  1  0 rs, 1 PC
- ALUSrcB  out  2  00 rt, 01 4, 10 sext imm, 11 sext imm<<2
- PCSource  out  2  00 ALU res, 01 ALU_Out, 10 jump target, 11 rs
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  conditional PC write
- Beq  out  1  1 = branch on zero, 0 = branch on ~zero
- ALU_operation  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR, 101 SRL, 011 XOR
- state  out  5  current state, for debug
- exc  out  1  overflow exception pulse

Behaviour:
- Reset: synchronous on the clk edge with reset=1. State goes to IF. All outputs are Moore-decoded, so every strobe is 0 in reset except the IF strobes on the following cycle; exc=0.
- Every strobe not listed for a state is 0 in that state.
- IF: MemRead=1, IorD=1, IRWrite=1, ALUSrcA=1, ALUSrcB=01, ALU ADD, PCSource=00, PCWrite=1.
  - Stay in IF while MIO_ready=0; go to ID when MIO_ready=1. The data path gates the PC and IR updates on MIO_ready.
- ID: ALUSrcA=1, ALUSrcB=11, ALU ADD (branch target into ALU_Out). Next state decoded from Inst_in[31:26] / [5:0]:
  - R-type → EX_R (jr funct 001000 → EX_JR)
  - lw/sw (100011/101011) → EX_MEM
  - beq 000100 → EX_BEQ; bne 000101 → EX_BNE
  - j 000010 → EX_J; jal 000011 → EX_JAL
  - addi/slti/andi/ori (001000/001010/001100/001101) → EX_I
  - lui 001111 → WB_LUI
  - any other encoding → IF (NOP)
- EX_R: ALUSrcA=0, ALUSrcB=00, ALU_operation from funct (add, sub, and, or, xor, nor, slt, srl). Unknown funct uses ADD. → WB_R.
- WB_R: RegDst=01, MemtoReg=00, RegWrite=1 → IF.
- EX_MEM: ALUSrcA=0, ALUSrcB=10, ADD. lw → MEM_RD; sw → MEM_WR.
- MEM_RD: MemRead=1, IorD=0. Hold until MIO_ready, then → WB_LW.
- WB_LW: RegDst=00, MemtoReg=01, RegWrite=1 → IF.
- MEM_WR: MemWrite=1, IorD=0. Hold until MIO_ready, then → IF.
- EX_BEQ / EX_BNE: ALUSrcA=0, ALUSrcB=00, SUB, PCWriteCond=1, PCSource=01. Beq=1 for EX_BEQ, Beq=0 for EX_BNE. → IF.
- EX_J: PCWrite=1, PCSource=10 → IF.
- EX_JAL: RegDst=10, MemtoReg=11, RegWrite=1, PCWrite=1, PCSource=10, all in one cycle. $31 receives the pre-update PC (already PC+4). → IF.
- EX_JR: PCWrite=1, PCSource=11 → IF.
- EX_I: ALUSrcA=0, ALUSrcB=10. Op is ADD/SLT/AND/OR for addi/slti/andi/ori. The immediate is sign-extended, which is the data path's fixed extension. → WB_I.
- WB_I: RegDst=00, MemtoReg=00, RegWrite=1 → IF.
- WB_LUI: RegDst=00, MemtoReg=10, RegWrite=1 → IF.
- Reset asserted in any state, including a memory wait, returns to IF next edge; the pending MemRead/MemWrite drops immediately.
- CPU latency: R/I-type 4 cycles, lw 5, sw 4, branch/jump 3. Each memory state adds one cycle per MIO_ready=0 cycle.

Optional Feature:
- Macro MCTRL_OVF_TRAP_EN.
- Defined:
  - EX_R (add/sub) and EX_I (addi) register overflow into ovf_q.
  - In the following WB state, if ovf_q=1: RegWrite is forced 0, exc pulses 1 for one cycle, ovf_q clears.
- Undefined: exc tied 0, no ovf_q, overflow ignored.

Decomposition:
- Shared package/header mcycle_defs: state encodings (5-bit localparams), opcode/funct constants, ALU_operation codes.
- One sub-module alu_dec: maps a 2-bit ALU class (add / sub / funct / imm-op) plus funct/opcode to ALU_operation; purely combinational.

Test Plan:
- Reset held 2 cycles mid-MEM_RD → state=IF, MemRead=1/IorD=1 the next cycle; no RegWrite seen.
- add $3,$1,$2 (0x00221820) with MIO_ready=1 → states IF,ID,EX_R,WB_R; ALU_operation=010 in EX_R; RegWrite=1, RegDst=01 in WB_R only.
- lw with MIO_ready low 3 cycles in MEM_RD → MemRead/IorD=0 held 4 cycles, then WB_LW with MemtoReg=01.
- bne (0x14220003) → EX_BNE: PCWriteCond=1, Beq=0, PCSource=01, ALU_operation=110.
- jal 0x0C000010 → EX_JAL: RegWrite=1, RegDst=10, MemtoReg=11, PCWrite=1, PCSource=10 in the same cycle.
- With MCTRL_OVF_TRAP_EN, add where overflow=1 in EX_R → WB_R RegWrite=0, exc=1 for exactly 1 cycle; undefined → RegWrite=1, exc=0.
